// File: rtl/prefix32sub_pipe_if.sv
// -----------------------------------------------------------------------------
// prefix32sub_pipe_if
// Operand/result bundle for the pipelined prefix subtractor.
//   master : drives in_valid, stall, a, b, bin; receives the result and flags
//   slave  : the subtractor side
// Optional feature macro: PREFIX_SUB_CMP_EN adds the compare outputs lt_u/lt_s.
// -----------------------------------------------------------------------------
interface prefix32sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             stall;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;
`ifdef PREFIX_SUB_CMP_EN
    logic             lt_u;
    logic             lt_s;
`endif

    modport master (
        output in_valid, stall, a, b, bin,
        input  out_valid, d, bout, zero, neg, ovf
`ifdef PREFIX_SUB_CMP_EN
        , input lt_u, lt_s
`endif
    );

    modport slave (
        input  in_valid, stall, a, b, bin,
        output out_valid, d, bout, zero, neg, ovf
`ifdef PREFIX_SUB_CMP_EN
        , output lt_u, lt_s
`endif
    );
endinterface

// File: rtl/prefix32sub_pipe.sv
// -----------------------------------------------------------------------------
// prefix32sub_pipe
// 32-bit pipelined parallel-prefix subtractor: d = a - b - bin (mod 2^32),
// computed as a + ~b + ~bin through a 5-level Sklansky (Ladner-Fischer style)
// generate/propagate tree with one register stage per level.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every pipeline register
//   bus   : prefix32sub_pipe_if.slave -- in_valid/stall/a/b/bin in,
//           out_valid/d/bout/zero/neg/ovf out (plus lt_u/lt_s, see below)
// Latency: an operation sampled at edge N is on the outputs after edge N+4.
// stall freezes every register, valid bits included; inputs during a stall
// are dropped.
// Optional feature macro: PREFIX_SUB_CMP_EN adds registered compare outputs
// lt_u = bout and lt_s = neg ^ ovf (meaningful when bin = 0).
// -----------------------------------------------------------------------------
module prefix32sub_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    prefix32sub_pipe_if.slave    bus
);

    // One in-flight slot: the running group generate/transmit terms plus the
    // per-bit propagate and sign bits that must stay aligned with them.
    typedef struct packed {
        logic             valid;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] k;
    } stage_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
`ifdef PREFIX_SUB_CMP_EN
        logic             lt_u;
        logic             lt_s;
`endif
    } result_t;

    // One Sklansky level: every bit whose index has bit 'lvl' set absorbs the
    // group term ending just below its 2^lvl-aligned block.
    function automatic stage_t prefix_level(input stage_t s, input int lvl);
        stage_t r;
        int     j;
        r = s;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> lvl) & 1) == 1) begin
                j = ((i >> lvl) << lvl) - 1;
                r.g[i] = s.g[i] | (s.k[i] & s.g[j]);
                r.k[i] = s.k[i] & s.k[j];
            end
        end
        return r;
    endfunction

    stage_t           stage_d [LAT-1];
    stage_t           stage_q [LAT-1];
    stage_t           in_s;
    stage_t           fin_s;
    result_t          res_d;
    result_t          res_q;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff;

    // NOTE: every variable assigned in this block gets a value up front, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        in_s       = '0;
        in_s.valid = bus.in_valid;
        in_s.cin   = ~bus.bin;
        in_s.a_msb = bus.a[WIDTH-1];
        in_s.b_msb = bus.b[WIDTH-1];
        in_s.p     = bus.a ^ ~bus.b;
        in_s.g     = bus.a & ~bus.b;
        in_s.k     = in_s.g | in_s.p;

        stage_d[0] = prefix_level(in_s, 0);
        for (int s = 1; s < LAT - 1; s++) begin
            stage_d[s] = prefix_level(stage_q[s-1], s);
        end

        // Last level, then fold the carry-in into the group terms.
        fin_s    = prefix_level(stage_q[LAT-2], LAT - 1);
        carry    = '0;
        carry[0] = fin_s.cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = fin_s.g[i] | (fin_s.k[i] & fin_s.cin);
        end
        // p comes from the same slot as the carries, never from the live input.
        diff = fin_s.p ^ carry[WIDTH-1:0];

        res_d       = '0;
        res_d.valid = fin_s.valid;
        res_d.d     = diff;
        res_d.bout  = ~carry[WIDTH];
        res_d.zero  = fin_s.valid & (diff == '0);
        res_d.neg   = diff[WIDTH-1];
        res_d.ovf   = (fin_s.a_msb != fin_s.b_msb) && (diff[WIDTH-1] != fin_s.a_msb);
`ifdef PREFIX_SUB_CMP_EN
        res_d.lt_u  = ~carry[WIDTH];
        res_d.lt_s  = diff[WIDTH-1] ^ res_d.ovf;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    // NOTE: the data fields are reset too, not just the valid bits, because the
    // outputs must read zero while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < LAT - 1; s++) begin
                stage_q[s] <= '0;
            end
            res_q <= '0;
        end else if (!bus.stall) begin
            for (int s = 0; s < LAT - 1; s++) begin
                stage_q[s] <= stage_d[s];
            end
            res_q <= res_d;
        end
    end

    assign bus.out_valid = res_q.valid;
    assign bus.d         = res_q.d;
    assign bus.bout      = res_q.bout;
    assign bus.zero      = res_q.zero;
    assign bus.neg       = res_q.neg;
    assign bus.ovf       = res_q.ovf;
`ifdef PREFIX_SUB_CMP_EN
    assign bus.lt_u      = res_q.lt_u;
    assign bus.lt_s      = res_q.lt_s;
`endif

endmodule
